// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_SHOW = 2'd3
    } scan_state_e;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Bits needed to hold a counter running 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_pulse_div.sv
// Free-running 0..DIV-1 counter with a registered one-cycle terminal-count flag.
module pulse_div
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tc_o
);

    localparam int unsigned   CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tc_q;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // tc_q is high exactly while cnt_q sits at the terminal count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tc_q  <= (DIV == 1);
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == LAST);
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan: feeds the registered coder one digit per slot,
// blanks three cycles at slot start and blinks masked digits in adjust mode.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        adj,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  number,
    input  logic [7:0]  code,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  scan_idx
);

    scan_state_e state_q;
    logic [1:0]  scan_idx_q;
    logic [3:0]  number_q;
    logic [3:0]  an_q;
    logic [7:0]  seg_q;
    logic        blink_ph_q;
    logic        slot_tc;
    logic        blink_tc;
    logic        blank;

    pulse_div #(.DIV(REFRESH_DIV)) u_slot_div (
        .clk_i (fclk),
        .rst_i (rst),
        .tc_o  (slot_tc)
    );

    pulse_div #(.DIV(BLINK_DIV)) u_blink_div (
        .clk_i (fclk),
        .rst_i (rst),
        .tc_o  (blink_tc)
    );

    assign blank = adj & blink_mask[scan_idx_q] & blink_ph_q;

    always_ff @(posedge fclk) begin
        if (rst) begin
            blink_ph_q <= 1'b0;
        end else if (blink_tc) begin
            blink_ph_q <= ~blink_ph_q;
        end
    end

    // Anode is only enabled once the coder output for this slot's digit is valid
    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            scan_idx_q <= 2'd0;
            number_q   <= 4'd0;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
        end else begin
            if (slot_tc) begin
                scan_idx_q <= scan_idx_q + 2'd1;
            end
            case (state_q)
                ST_LOAD: begin
                    number_q <= digits[{scan_idx_q, 2'b00} +: 4];
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_q <= ST_CAPT;
                end
                ST_CAPT: begin
                    if (!blank) begin
                        seg_q <= code;
                        an_q  <= ~(4'b0001 << scan_idx_q);
                    end
                    state_q <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (slot_tc) begin
                        seg_q   <= SEG_OFF;
                        an_q    <= AN_OFF;
                        state_q <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    assign number   = number_q;
    assign seg      = seg_q;
    assign an       = an_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a registered hex coder attached; expectations come
// from a time-indexed model of the slot schedule over recorded input history.
module tb_seg_scan_ctrl;

    localparam int RD   = 8;
    localparam int BD   = 64;
    localparam int HMAX = 8192;

    logic        fclk       = 1'b0;
    logic        rst        = 1'b1;
    logic [15:0] digits     = 16'h1234;
    logic        adj        = 1'b0;
    logic [3:0]  blink_mask = 4'b0000;
    logic [3:0]  number;
    logic [7:0]  code       = 8'hFF;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  scan_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;

    logic [15:0] h_dig  [HMAX];
    logic        h_adj  [HMAX];
    logic [3:0]  h_mask [HMAX];

    typedef struct packed {
        logic        rst;
        logic [15:0] dig;
        logic [3:0]  an;
        logic [7:0]  seg;
        logic [3:0]  num;
        logic [1:0]  idx;
    } vec_t;

    vec_t tbl [17];

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .fclk       (fclk),
        .rst        (rst),
        .digits     (digits),
        .adj        (adj),
        .blink_mask (blink_mask),
        .number     (number),
        .code       (code),
        .seg        (seg),
        .an         (an),
        .scan_idx   (scan_idx)
    );

    always #5 fclk = ~fclk;

    function automatic logic [7:0] enc(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] d, input int i);
        return d[i*4 +: 4];
    endfunction

    // Registered coder beside the controller
    always @(posedge fclk) code <= enc(number);

    // k = edges since reset release; h_* hold the inputs seen at edge k
    always @(posedge fclk) begin
        if (rst) begin
            k = 0;
        end else if (k < HMAX - 1) begin
            k = k + 1;
            h_dig[k]  = digits;
            h_adj[k]  = adj;
            h_mask[k] = blink_mask;
        end
    end

    task automatic model(output logic [3:0] e_an, output logic [7:0] e_seg,
                         output logic [3:0] e_num, output logic [1:0] e_idx);
        int  tick, idx, le, li, ce;
        logic ph;
        tick  = k % RD;
        idx   = (k / RD) % 4;
        e_idx = 2'(idx);
        e_an  = 4'hF;
        e_seg = 8'hFF;
        e_num = 4'h0;
        if (k > 0) begin
            if (tick >= 1) begin
                le = k - tick + 1;
                li = idx;
            end else begin
                le = k - RD + 1;
                li = (idx + 3) % 4;
            end
            e_num = nib(h_dig[le], li);
            if (tick >= 3) begin
                ce = k - tick + 3;
                ph = (((ce - 1) / BD) % 2) == 1;
                if (!(h_adj[ce] && h_mask[ce][idx] && ph)) begin
                    e_an  = ~(4'b0001 << idx);
                    e_seg = enc(nib(h_dig[k - tick + 1], idx));
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: k=%0d got %0h expected %0h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] ea, en;
        logic [7:0] es;
        logic [1:0] ei;
        model(ea, es, en, ei);
        chk("model_an", 16'(an), 16'(ea));
        chk("model_seg", 16'(seg), 16'(es));
        chk("model_number", 16'(number), 16'(en));
        chk("model_scan_idx", 16'(scan_idx), 16'(ei));
    endtask

    task automatic step();
        @(posedge fclk);
        #1;
        check_model();
    endtask

    task automatic wait_k(input int target);
        int guard = 0;
        while (k != target && guard < 1000) begin
            step();
            guard++;
        end
        if (k != target) chk("wait_k_timeout", 16'(k), 16'(target));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'h1234, 4'hF, 8'hFF, 4'h0, 2'd0};
        tbl[1]  = '{1'b0, 16'h1234, 4'hF, 8'hFF, 4'h4, 2'd0};
        tbl[2]  = '{1'b0, 16'h1234, 4'hF, 8'hFF, 4'h4, 2'd0};
        tbl[3]  = '{1'b0, 16'h1234, 4'hE, 8'h99, 4'h4, 2'd0};
        tbl[4]  = '{1'b0, 16'h1234, 4'hE, 8'h99, 4'h4, 2'd0};
        tbl[5]  = '{1'b0, 16'h1234, 4'hE, 8'h99, 4'h4, 2'd0};
        tbl[6]  = '{1'b0, 16'h1234, 4'hE, 8'h99, 4'h4, 2'd0};
        tbl[7]  = '{1'b0, 16'h1234, 4'hE, 8'h99, 4'h4, 2'd0};
        tbl[8]  = '{1'b0, 16'h1234, 4'hF, 8'hFF, 4'h4, 2'd1};
        tbl[9]  = '{1'b0, 16'h1234, 4'hF, 8'hFF, 4'h3, 2'd1};
        tbl[10] = '{1'b0, 16'h1234, 4'hF, 8'hFF, 4'h3, 2'd1};
        tbl[11] = '{1'b0, 16'h1234, 4'hD, 8'hB0, 4'h3, 2'd1};
        tbl[12] = '{1'b0, 16'h1234, 4'hD, 8'hB0, 4'h3, 2'd1};
        tbl[13] = '{1'b0, 16'h1234, 4'hD, 8'hB0, 4'h3, 2'd1};
        tbl[14] = '{1'b0, 16'h1234, 4'hD, 8'hB0, 4'h3, 2'd1};
        tbl[15] = '{1'b0, 16'h1234, 4'hD, 8'hB0, 4'h3, 2'd1};
        tbl[16] = '{1'b0, 16'h1234, 4'hF, 8'hFF, 4'h3, 2'd2};

        // Reset and first two slots against fixed vectors
        for (int i = 0; i < 17; i++) begin
            rst    = tbl[i].rst;
            digits = tbl[i].dig;
            @(posedge fclk);
            #1;
            chk("tbl_an", 16'(an), 16'(tbl[i].an));
            chk("tbl_seg", 16'(seg), 16'(tbl[i].seg));
            chk("tbl_number", 16'(number), 16'(tbl[i].num));
            chk("tbl_scan_idx", 16'(scan_idx), 16'(tbl[i].idx));
        end

        // Rest of the first frame
        wait_k(19);
        chk("frame_an2", 16'(an), 16'h000B);
        chk("frame_seg2", 16'(seg), 16'h00A4);
        wait_k(27);
        chk("frame_an3", 16'(an), 16'h0007);
        chk("frame_seg3", 16'(seg), 16'h00F9);
        chk("frame_num3", 16'(number), 16'h0001);
        wait_k(32);
        chk("frame_wrap_idx", 16'(scan_idx), 16'h0000);
        chk("frame_wrap_an", 16'(an), 16'h000F);

        // Mid-slot digits change only affects the following slot
        wait_k(37);
        digits = 16'h9999;
        wait_k(39);
        chk("midslot_seg", 16'(seg), 16'h0099);
        chk("midslot_num", 16'(number), 16'h0004);
        wait_k(41);
        chk("next_slot_num", 16'(number), 16'h0009);
        wait_k(43);
        chk("next_slot_an", 16'(an), 16'h000D);
        chk("next_slot_seg", 16'(seg), 16'h0090);

        // Blink digit 1 in adjust mode
        adj        = 1'b1;
        blink_mask = 4'b0010;
        wait_k(77);
        chk("blink_on_an", 16'(an), 16'h000F);
        chk("blink_on_seg", 16'(seg), 16'h00FF);
        wait_k(85);
        chk("blink_other_an", 16'(an), 16'h000B);
        wait_k(141);
        chk("blink_off_an", 16'(an), 16'h000D);
        chk("blink_off_seg", 16'(seg), 16'h0090);

        // One-cycle reset at tick 4 of a digit-2 slot
        wait_k(148);
        chk("pre_rst_idx", 16'(scan_idx), 16'h0002);
        rst = 1'b1;
        step();
        chk("rst_an", 16'(an), 16'h000F);
        chk("rst_seg", 16'(seg), 16'h00FF);
        chk("rst_idx", 16'(scan_idx), 16'h0000);
        rst = 1'b0;
        step();
        chk("restart_num", 16'(number), 16'h0009);
        step();
        step();
        chk("restart_an", 16'(an), 16'h000E);
        chk("restart_seg", 16'(seg), 16'h0090);

        // Randomized run with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 49) == 0) adj = ~adj;
            if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the four-digit seven-segment display. It sequences the shared registered `coder` (number→segment encoder) across four BCD/hex digits and drives the anode selects. It accounts for the coder's one-cycle registered latency, blanks between digits to prevent ghosting, and blinks selected digits in adjust mode. It sits between the stopwatch/counter core (digit source) and the board display pins.

## Interface
- `REFRESH_DIV`, 50000: `fclk` cycles per digit slot; minimum 4.
- `BLINK_DIV`, 25000000: `fclk` cycles per blink half-period; minimum 1.
- `fclk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `digits`  in  16  four nibbles; digit i = `digits[4i+3:4i]`, digit 0 rightmost.
- `adj`  in  1  adjust mode; enables blinking.
- `blink_mask`  in  4  per-digit blink enable, bit i ↔ digit i.
- `number`  out  4  registered value presented to the coder.
- `code`  in  8  coder output, active-low segments + dp, valid one cycle after `number` is latched by the coder.
- `seg`  out  8  registered segment drive, active-low.
- `an`  out  4  registered anode select, active-low one-hot; 4'b1111 = all off.
- `scan_idx`  out  2  digit index of the current slot.

## Operation
- Slot counter `tick` runs 0..REFRESH_DIV-1. At the terminal count: `tick`←0, `scan_idx`←`scan_idx`+1 (wraps 3→0), state←LOAD.
- States, one per cycle except SHOW:
  - LOAD (tick 0): `an`=1111, `seg`=FF. Exit edge: `number`←digit[`scan_idx`], →WAIT.
  - WAIT (tick 1): coder latches `number`. →CAPT.
  - CAPT (tick 2): exit edge: if blanked, `an` and `seg` stay off; else `seg`←`code`, `an`←~(1<<`scan_idx`). →SHOW.
  - SHOW (tick 3..REFRESH_DIV-1): outputs hold. Exit at terminal count: `an`←1111, `seg`←FF, →LOAD.
- Blanked = `adj` & `blink_mask[scan_idx]` & `blink_ph`.
- `blink_ph` toggles each time `blink_cnt` (0..BLINK_DIV-1) wraps. The blanking decision is sampled only at CAPT exit, so a `blink_ph` change mid-slot takes effect in the next slot.
- `digits` is sampled only at LOAD exit; changes mid-slot do not alter the displayed slot.
- Only one `an` bit is ever low. `an` is never low while `seg` holds a stale value.

## Timing
- Reset values (sync, on the edge where `rst`=1, any state): state=LOAD, `tick`=0, `scan_idx`=0, `number`=0, `seg`=8'hFF, `an`=4'b1111, `blink_cnt`=0, `blink_ph`=0.
- First edge with `rst`=0: `number`←digit 0. Anode goes active at the 3rd edge after reset release.
- Each slot is exactly REFRESH_DIV cycles. Anode is active for REFRESH_DIV-3 cycles, and blank for 3 cycles at the slot start.
- Full scan frame = 4·REFRESH_DIV cycles.
- `rst` asserted mid-SHOW: the next edge forces all reset values. There is no partial-slot completion.

## Structure
- Package `seg_scan_pkg`:
  - state encoding (LOAD, WAIT, CAPT, SHOW);
  - `AN_OFF`=4'b1111, `SEG_OFF`=8'hFF;
  - width function for the counters.
- Sub-module `pulse_div` (parameter DIV): free-running counter emitting a one-cycle terminal pulse. Instantiated twice: slot tick and blink toggle.
- `coder` is instantiated beside this block in the display top, not inside it.

## Test plan
Bench parameters: REFRESH_DIV=8, BLINK_DIV=64, real `coder` attached.
- Reset, `digits`=16'h1234, `adj`=0.
  - `number`=4 at the 1st edge after release.
  - `an`=1110 from the 3rd edge, for 5 cycles.
  - `seg` = coder code for 4.
- Full frame.
  - `scan_idx` sequence 0,1,2,3,0 every 8 cycles.
  - `number` sequence 4,3,2,1.
  - `an` sequence 1110,1101,1011,0111.
  - `an`=1111 for 3 cycles between digits.
- `digits` changed to 16'h9999 at tick 5 of slot 0: slot 0 still shows 4; slot 1 shows 9.
- `adj`=1, `blink_mask`=4'b0010: digit 1 slots are fully blank while `blink_ph`=1 and normal while 0; other digits are unaffected.
- `rst` pulsed for 1 cycle at tick 4 of slot 2: next edge gives `an`=1111, `seg`=FF, `scan_idx`=0; restart as in scenario 1.
